// File: rtl/datapath_mc_if.sv
// Control and memory-bus bundle for datapath_mc. The control FSM / memory side
// connects through the master modport, the datapath through the slave modport.
interface datapath_mc_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       AluOp;
  logic [1:0]       Op1Sel;
  logic [1:0]       Op2Sel;
  logic             ImmSel;
  logic [1:0]       PcSel;
  logic             PcWe;
  logic             SpWe;
  logic             LrWe;
  logic             AluWe;
  logic             RegWe;
  logic             WdSel;
  logic [2:0]       MemOp;
  logic             MemStart;
  logic             MemBusy;
  logic             MemDone;
  logic [WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0] MemWData;
  logic [WIDTH-1:0] MemRData;
  logic             MemReq;
  logic             MemWr;
  logic             MemAck;
  logic [7:0]       Opcode;
  logic [3:0]       Flags;
  logic [WIDTH-1:0] Pc;

  modport master (
    output AluOp, Op1Sel, Op2Sel, ImmSel, PcSel, PcWe, SpWe, LrWe, AluWe, RegWe,
           WdSel, MemOp, MemStart, MemRData, MemAck,
    input  MemBusy, MemDone, MemAddr, MemWData, MemReq, MemWr, Opcode, Flags, Pc
  );

  modport slave (
    input  AluOp, Op1Sel, Op2Sel, ImmSel, PcSel, PcWe, SpWe, LrWe, AluWe, RegWe,
           WdSel, MemOp, MemStart, MemRData, MemAck,
    output MemBusy, MemDone, MemAddr, MemWData, MemReq, MemWr, Opcode, Flags, Pc
  );
endinterface

// File: rtl/datapath_mc.sv
// Multicycle CPU datapath: register file, PC/SP/LR/IR/ALUOUT/MDR, ALU with flags,
// and a fetch/load/store/push/pop memory sequencer with req/ack handshake.
module datapath_mc #(
  parameter int               WIDTH    = 16,
  parameter int               NREGS    = 8,
  parameter logic [WIDTH-1:0] PC_RESET = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(16'hFFFF)
) (
  input logic          Clock,
  input logic          nReset,
  datapath_mc_if.slave bus
);
  localparam int               RA_W     = $clog2(NREGS);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]       OP_FETCH = 3'd1;
  localparam logic [2:0]       OP_LOAD  = 3'd2;
  localparam logic [2:0]       OP_STORE = 3'd3;
  localparam logic [2:0]       OP_PUSH  = 3'd4;
  localparam logic [2:0]       OP_POP   = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, PREDEC = 2'd1, REQ = 2'd2, DONE = 2'd3} seq_state_t;

  seq_state_t       state_r, state_s;
  logic [WIDTH-1:0] pc_r, sp_r, lr_r, ir_r, aluout_r, mdr_r;
  logic [3:0]       flags_r;
  logic [WIDTH-1:0] regs_r [NREGS];
  logic [2:0]       op_r;
  logic             mem_busy_r, mem_done_r, mem_req_r, mem_wr_r;
  logic [WIDTH-1:0] mem_addr_r, mem_wdata_r;

  logic [RA_W-1:0]  rw_s, rs1_s, rs2_s;
  logic [WIDTH-1:0] rd1_s, rd2_s, imm_s, op1_s, op2_s, alu_res_s, pc_mux_s, addr_s;
  logic [WIDTH:0]   sum_s, sh_s;
  logic             alu_c_s, alu_v_s, start_s, ack_s, busy_s;
  logic [3:0]       flags_s;
  logic [2:0]       next_op_s;

  assign rw_s  = ir_r[RA_W-1:0];
  assign rs1_s = ir_r[2*RA_W-1:RA_W];
  assign rs2_s = ir_r[3*RA_W-1:2*RA_W];
  assign rd1_s = regs_r[rs1_s];
  assign rd2_s = regs_r[rs2_s];
  assign imm_s = bus.ImmSel ? {{(WIDTH-8){ir_r[7]}}, ir_r[7:0]}
                            : {{(WIDTH-5){ir_r[10]}}, ir_r[10:6]};

  // ALU operand selection
  always_comb begin
    op1_s = rd1_s;
    op2_s = imm_s;
    case (bus.Op1Sel)
      2'd0:    op1_s = rd1_s;
      2'd1:    op1_s = pc_r;
      2'd2:    op1_s = sp_r;
      2'd3:    op1_s = lr_r;
      default: op1_s = rd1_s;
    endcase
    case (bus.Op2Sel)
      2'd0:    op2_s = imm_s;
      2'd1:    op2_s = {imm_s[WIDTH-3:0], 2'b00};
      2'd2:    op2_s = rd2_s;
      2'd3:    op2_s = ONE;
      default: op2_s = imm_s;
    endcase
  end

  // ALU; SUB is Op1 + ~Op2 + 1 so its carry out is already NOT borrow, and the
  // shifts run one bit wider so the last bit shifted out lands in the spare bit
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    sum_s     = {(WIDTH+1){1'b0}};
    sh_s      = {(WIDTH+1){1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.AluOp)
      4'd0, 4'd10: begin
        sum_s     = {1'b0, op1_s} + {1'b0, op2_s}
                  + {{WIDTH{1'b0}}, (bus.AluOp == 4'd10) & flags_r[1]};
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (op1_s[WIDTH-1] == op2_s[WIDTH-1]) && (sum_s[WIDTH-1] != op1_s[WIDTH-1]);
      end
      4'd1: begin
        sum_s     = {1'b0, op1_s} + {1'b0, ~op2_s} + {{WIDTH{1'b0}}, 1'b1};
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (op1_s[WIDTH-1] != op2_s[WIDTH-1]) && (sum_s[WIDTH-1] != op1_s[WIDTH-1]);
      end
      4'd2: alu_res_s = op1_s & op2_s;
      4'd3: alu_res_s = op1_s | op2_s;
      4'd4: alu_res_s = op1_s ^ op2_s;
      4'd5: alu_res_s = ~op1_s;
      4'd6: begin
        sh_s      = {1'b0, op1_s} << op2_s[3:0];
        alu_res_s = sh_s[WIDTH-1:0];
        alu_c_s   = sh_s[WIDTH];
      end
      4'd7: begin
        sh_s      = {op1_s, 1'b0} >> op2_s[3:0];
        alu_res_s = sh_s[WIDTH:1];
        alu_c_s   = sh_s[0];
      end
      4'd8: begin
        sh_s      = $unsigned($signed({op1_s, 1'b0}) >>> op2_s[3:0]);
        alu_res_s = sh_s[WIDTH:1];
        alu_c_s   = sh_s[0];
      end
      4'd9:    alu_res_s = op2_s;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  assign flags_s = {alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}}), alu_c_s, alu_v_s};

  // PC source selection
  always_comb begin
    pc_mux_s = pc_r;
    case (bus.PcSel)
      2'd0:    pc_mux_s = lr_r;
      2'd1:    pc_mux_s = aluout_r;
      2'd2:    pc_mux_s = mdr_r;
      2'd3:    pc_mux_s = pc_r + ONE;
      default: pc_mux_s = pc_r;
    endcase
  end

  assign busy_s    = (state_r != IDLE);
  assign start_s   = (state_r == IDLE) && bus.MemStart &&
                     (bus.MemOp >= OP_FETCH) && (bus.MemOp <= OP_POP);
  assign ack_s     = (state_r == REQ) && bus.MemAck;
  assign next_op_s = start_s ? bus.MemOp : op_r;

  // Sequencer next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = (bus.MemOp == OP_PUSH) ? PREDEC : REQ;
        end else begin
          state_s = IDLE;
        end
      end
      PREDEC: state_s = REQ;
      REQ: begin
        if (bus.MemAck) begin
          state_s = DONE;
        end else begin
          state_s = REQ;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Transfer address; push targets the value SP is being decremented to
  always_comb begin
    addr_s = mem_addr_r;
    case (next_op_s)
      OP_FETCH:          addr_s = pc_r;
      OP_LOAD, OP_STORE: addr_s = aluout_r;
      OP_PUSH:           addr_s = sp_r - ONE;
      OP_POP:            addr_s = sp_r;
      default:           addr_s = mem_addr_r;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered bus outputs; address/data are latched once so they hold through wait states
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      op_r        <= 3'd0;
      mem_busy_r  <= 1'b0;
      mem_done_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= {WIDTH{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
    end else begin
      mem_busy_r <= (state_s != IDLE);
      mem_done_r <= (state_s == DONE);
      mem_req_r  <= (state_s == REQ);
      mem_wr_r   <= (state_s == REQ) && ((next_op_s == OP_STORE) || (next_op_s == OP_PUSH));
      if (start_s) begin
        op_r <= bus.MemOp;
      end
      if (start_s && ((bus.MemOp == OP_STORE) || (bus.MemOp == OP_PUSH))) begin
        mem_wdata_r <= rd2_s;
      end
      if ((state_s == REQ) && (state_r != REQ)) begin
        mem_addr_r <= addr_s;
      end
    end
  end

  // Architectural registers; sequencer PC/SP updates take precedence while busy
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_r     <= PC_RESET;
      sp_r     <= SP_RESET;
      lr_r     <= {WIDTH{1'b0}};
      ir_r     <= {WIDTH{1'b0}};
      aluout_r <= {WIDTH{1'b0}};
      mdr_r    <= {WIDTH{1'b0}};
      flags_r  <= 4'd0;
    end else begin
      if (ack_s && (op_r == OP_FETCH)) begin
        pc_r <= pc_r + ONE;
        ir_r <= bus.MemRData;
      end else if (!busy_s && bus.PcWe) begin
        pc_r <= pc_mux_s;
      end
      if (state_r == PREDEC) begin
        sp_r <= sp_r - ONE;
      end else if (ack_s && (op_r == OP_POP)) begin
        sp_r <= sp_r + ONE;
      end else if (!busy_s && bus.SpWe) begin
        sp_r <= alu_res_s;
      end
      if (ack_s && ((op_r == OP_LOAD) || (op_r == OP_POP))) begin
        mdr_r <= bus.MemRData;
      end
      if (bus.LrWe) begin
        lr_r <= pc_r;
      end
      if (bus.AluWe) begin
        aluout_r <= alu_res_s;
        flags_r  <= flags_s;
      end
    end
  end

  // Register file write port
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (bus.RegWe) begin
        regs_r[rw_s] <= bus.WdSel ? mdr_r : aluout_r;
      end
    end
  end

  assign bus.MemBusy  = mem_busy_r;
  assign bus.MemDone  = mem_done_r;
  assign bus.MemReq   = mem_req_r;
  assign bus.MemWr    = mem_wr_r;
  assign bus.MemAddr  = mem_addr_r;
  assign bus.MemWData = mem_wdata_r;
  assign bus.Opcode   = ir_r[WIDTH-1 -: 8];
  assign bus.Flags    = flags_r;
  assign bus.Pc       = pc_r;
endmodule
